// File: rtl/pla_seq_eval.sv
// pla_seq_eval: run-time programmable sum-of-products (PLA cube list) evaluator.
// Cubes are written through a config port. Input vectors arrive on a valid/ready
// handshake. Product terms are evaluated TPC at a time, OR-reduced per output,
// corrected by output polarity, and returned on a second valid/ready handshake.
module pla_seq_eval #(
  parameter int N_IN    = 12,
  parameter int N_OUT   = 1,
  parameter int N_TERMS = 16,
  parameter int TPC     = 4,
  parameter int AW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  // cube / polarity configuration
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [N_IN-1:0]  cfg_care,
  input  logic [N_IN-1:0]  cfg_val,
  input  logic [N_OUT-1:0] cfg_omask,
  input  logic [N_OUT-1:0] cfg_pol,
  input  logic             cfg_pol_we,
  output logic             cfg_busy,
  // input vector handshake
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_x,
  // result handshake
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_y
);

  // Number of term groups, and a group counter wide enough to hold K itself
  // so it cannot wrap before the last group has been processed.
  localparam int K  = N_TERMS / TPC;
  localparam int GW = $clog2(K) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [GW-1:0]    grp_q;
  logic [N_IN-1:0]  x_q;
  logic [N_OUT-1:0] acc_q;
  logic [N_OUT-1:0] pol_q;

  // Cube storage: care/val describe the literal pattern, omask enables the cube
  // per output. Only omask is cleared by reset; care/val are don't-care while
  // the matching omask is zero.
  logic [N_IN-1:0]  care_mem  [N_TERMS];
  logic [N_IN-1:0]  val_mem   [N_TERMS];
  logic [N_OUT-1:0] omask_mem [N_TERMS];

  logic [N_TERMS-1:0] term_hit;
  logic [N_OUT-1:0]   grp_res;

  logic cfg_open;
  logic accept;
  logic last_grp;
  logic cube_we;
  logic pol_we;

  // Configuration and vector acceptance are both only open in IDLE, so an
  // evaluation in flight always sees a frozen cube list.
  assign cfg_open = (state_q == IDLE);
  assign cfg_busy = ~cfg_open;
  assign in_ready = cfg_open;
  assign accept   = in_valid & cfg_open;
  assign last_grp = (grp_q == GW'(K - 1));
  assign cube_we  = cfg_we & cfg_open;
  assign pol_we   = cfg_pol_we & cfg_open;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for IDLE -> EVAL -> DONE -> IDLE.
  always_comb begin
    // NOTE: the default assignment before the case keeps every path assigned,
    // so no latch is inferred for state_d.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = EVAL;
      EVAL:    if (last_grp)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Per-term literal match against the latched vector: a term matches when
  // every cared-for bit equals its required value.
  always_comb begin
    term_hit = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      term_hit[t] = (((x_q ^ val_mem[t]) & care_mem[t]) == '0);
    end
  end

  // OR together the output masks of the matching terms in the current group.
  always_comb begin
    grp_res = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      if ((grp_q == GW'(t / TPC)) && term_hit[t]) begin
        grp_res = grp_res | omask_mem[t];
      end
    end
  end

  // Evaluation datapath: latch vector, accumulate groups, present and hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      acc_q     <= '0;
      grp_q     <= '0;
      out_y     <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            x_q   <= in_x;
            acc_q <= '0;
            grp_q <= '0;
          end
        end
        EVAL: begin
          acc_q <= acc_q | grp_res;
          grp_q <= grp_q + 1'b1;
          if (last_grp) begin
            out_y     <= pol_q ^ (acc_q | grp_res);
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Cube literal storage, written only while idle.
  always_ff @(posedge clk) begin
    // NOTE: care/val are plain storage with no reset; an unprogrammed cube is
    // neutralised by its cleared omask, so clearing the literals buys nothing.
    for (int t = 0; t < N_TERMS; t++) begin
      if (cube_we && (cfg_addr == AW'(t))) begin
        care_mem[t] <= cfg_care;
        val_mem[t]  <= cfg_val;
      end
    end
  end

  // Cube output masks and output polarity; both cleared by reset so an
  // unprogrammed PLA evaluates to 0. Addresses beyond N_TERMS decode to nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < N_TERMS; t++) begin
        omask_mem[t] <= '0;
      end
      pol_q <= '0;
    end else begin
      for (int t = 0; t < N_TERMS; t++) begin
        if (cube_we && (cfg_addr == AW'(t))) begin
          omask_mem[t] <= cfg_omask;
        end
      end
      if (pol_we) begin
        pol_q <= cfg_pol;
      end
    end
  end

endmodule

// File: tb/tb_pla_seq_eval.sv
// Directed self-checking bench for pla_seq_eval at default parameters.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_pla_seq_eval;

  localparam int N_IN    = 12;
  localparam int N_OUT   = 1;
  localparam int N_TERMS = 16;
  localparam int TPC     = 4;
  localparam int AW      = 4;
  localparam int LAT     = N_TERMS / TPC;

  logic             clk;
  logic             rst;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [N_IN-1:0]  cfg_care;
  logic [N_IN-1:0]  cfg_val;
  logic [N_OUT-1:0] cfg_omask;
  logic [N_OUT-1:0] cfg_pol;
  logic             cfg_pol_we;
  logic             cfg_busy;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_x;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_y;

  int n_checks = 0;
  int n_errors = 0;

  pla_seq_eval #(
    .N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS), .TPC(TPC), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care), .cfg_val(cfg_val),
    .cfg_omask(cfg_omask), .cfg_pol(cfg_pol), .cfg_pol_we(cfg_pol_we),
    .cfg_busy(cfg_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cube(input logic [AW-1:0] addr, input logic [N_IN-1:0] care,
                            input logic [N_IN-1:0] val, input logic [N_OUT-1:0] omask);
    cfg_we = 1'b1; cfg_addr = addr; cfg_care = care; cfg_val = val; cfg_omask = omask;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic write_pol(input logic [N_OUT-1:0] pol);
    cfg_pol_we = 1'b1; cfg_pol = pol;
    step();
    cfg_pol_we = 1'b0;
  endtask

  // Present a vector, wait (bounded) for in_ready, return just after the accept edge.
  // in_x is then scrambled to show the latched copy is what gets evaluated.
  task automatic send(input string tag, input logic [N_IN-1:0] x);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    if (waited >= 20) check({tag, "_rdy_timeout"}, 0, 1);
    in_valid = 1'b1; in_x = x;
    step();
    in_valid = 1'b0;
    in_x = N_IN'($urandom());
  endtask

  // Count edges since accept until out_valid, check latency and value, then consume.
  task automatic wait_result(input string tag, input logic [N_OUT-1:0] exp_y, input int lat0);
    int lat = lat0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_y"}, 32'(out_y), 32'(exp_y));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_clr"}, 32'(out_valid), 0);
  endtask

  task automatic run_vec(input string tag, input logic [N_IN-1:0] x, input logic [N_OUT-1:0] exp_y);
    send(tag, x);
    wait_result(tag, exp_y, 0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_care = '0; cfg_val = '0;
    cfg_omask = '0; cfg_pol = '0; cfg_pol_we = 1'b0;
    in_valid = 1'b0; in_x = '0; out_ready = 1'b0;

    // 1: reset state and an unprogrammed PLA
    repeat (3) step();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_y", 32'(out_y), 0);
    rst = 1'b0;
    step();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_cfg_busy", 32'(cfg_busy), 0);
    run_vec("t1_empty", 12'hFFF, 1'b0);

    // 2: single cube with literals on bits 8,7,4,2,0
    write_cube(4'd0, 12'h195, 12'h011, 1'b1);
    run_vec("t2_match", 12'h011, 1'b1);
    run_vec("t2_x7", 12'h091, 1'b0);
    run_vec("t2_x2", 12'h015, 1'b0);
    run_vec("t2_dc_bit", 12'h013, 1'b1);

    // 3: tautology cube in the last slot (last group), then inverted polarity
    write_cube(4'd15, 12'h000, 12'h000, 1'b1);
    run_vec("t3_taut0", 12'h000, 1'b1);
    run_vec("t3_tautabc", 12'hABC, 1'b1);
    write_pol(1'b1);
    run_vec("t3_pol0", 12'h000, 1'b0);
    run_vec("t3_polabc", 12'hABC, 1'b0);
    write_pol(1'b0);
    write_cube(4'd15, 12'h000, 12'h000, 1'b0);
    run_vec("t3_off", 12'hABC, 1'b0);

    // 4: backpressure with a second vector waiting
    send("t4_a", 12'h011);
    begin
      int lat = 0;
      while (!out_valid && lat < 20) begin
        step();
        lat++;
      end
      check("t4_lat", lat, LAT);
    end
    in_valid = 1'b1; in_x = 12'h000;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4_hold_y", 32'(out_y), 1);
      check("t4_hold_valid", 32'(out_valid), 1);
      check("t4_hold_rdy", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4_rel_valid", 32'(out_valid), 0);
    check("t4_rel_rdy", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("t4_b_busy", 32'(cfg_busy), 1);
    wait_result("t4_b", 1'b0, 0);

    // 5: cube write during EVAL is dropped
    send("t5_a", 12'h011);
    check("t5_busy", 32'(cfg_busy), 1);
    write_cube(4'd0, 12'h195, 12'h011, 1'b0);
    wait_result("t5_a", 1'b1, 1);
    run_vec("t5_b", 12'h011, 1'b1);

    // 6: reset in the middle of EVAL
    send("t6_a", 12'h011);
    step();
    rst = 1'b1;
    step();
    check("t6_rst_valid", 32'(out_valid), 0);
    step();
    rst = 1'b0;
    step();
    check("t6_rdy", 32'(in_ready), 1);
    check("t6_busy", 32'(cfg_busy), 0);
    repeat (LAT + 2) step();
    check("t6_no_valid", 32'(out_valid), 0);
    run_vec("t6_fresh", 12'h011, 1'b0);

    // 7: cube and polarity written in the same cycle both take effect
    cfg_we = 1'b1; cfg_addr = 4'd5; cfg_care = 12'h000; cfg_val = 12'h000; cfg_omask = 1'b1;
    cfg_pol_we = 1'b1; cfg_pol = 1'b1;
    step();
    cfg_we = 1'b0; cfg_pol_we = 1'b0;
    run_vec("t7_both", 12'h5A5, 1'b0);
    write_pol(1'b0);
    run_vec("t7_pol0", 12'h5A5, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
